// File: rtl/key_adjust_ctrl_pkg.sv
// Shared definitions for the manual time-set key front-ends: channel FSM
// states, default timing constants and the timer-width helper.
package key_adjust_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ARM,
        PULSE,
        GAP,
        GUARD
    } key_state_e;

    // Default timings in clk cycles, shared with other key front-ends.
    localparam int KEY_DEB_CYC_DEF  = 20;
    localparam int KEY_HOLD_CYC_DEF = 500;
    localparam int KEY_REP_CYC_DEF  = 200;

    // Bits needed to hold 0..max_val; never less than one bit.
    function automatic int timer_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/key_adjust_ctrl_debounce.sv
// key_debounce: synchroniser chain plus debounce counter for one raw key.
// stable flips once the synced level has differed from it for DEB_CYC
// consecutive cycles. rise is a registered one-cycle pulse aligned with
// stable going high. fall is asserted during the cycle whose closing edge
// drops stable, so a release can take priority over an event landing on
// that same edge.
module key_debounce
    import key_adjust_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = KEY_DEB_CYC_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic key,
    output logic stable,
    output logic rise,
    output logic fall
);

    localparam int CW = timer_width(DEB_CYC);
    localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CYC - 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   stable_reg;
    logic                   rise_reg;
    logic                   synced;
    logic                   flip;

    assign synced = sync_reg[SYNC_STAGES-1];
    assign flip   = (synced != stable_reg) && (cnt_reg == DEB_LAST);

    // Shift the asynchronous key through the synchroniser chain.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[SYNC_STAGES-2:0], key};
        end
    end

    // Count cycles of disagreement; flip the stable level when the run is long enough.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_reg    <= '0;
            stable_reg <= 1'b0;
            rise_reg   <= 1'b0;
        end else begin
            rise_reg <= flip & synced;
            if ((synced == stable_reg) || flip) begin
                cnt_reg <= '0;
            end else begin
                cnt_reg <= cnt_reg + CW'(1);
            end
            if (flip) begin
                stable_reg <= synced;
            end
        end
    end

    assign stable = stable_reg;
    assign rise   = rise_reg;
    assign fall   = flip & ~synced;

endmodule

// File: rtl/key_adjust_ctrl.sv
// key_adjust_ctrl: turns the raw minute/hour buttons into glitch-free step
// clocks (madd/hadd) and their mux selects (madd_sig/hadd_sig). Each channel
// debounces its key, then an FSM frames every step with a select setup cycle
// before add rises and a guard period after it falls. Holding the key
// auto-repeats: first repeat HOLD_CYC after the first step, then every REP_CYC.
module key_adjust_ctrl
    import key_adjust_ctrl_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYC     = KEY_DEB_CYC_DEF,
    parameter int HOLD_CYC    = KEY_HOLD_CYC_DEF,
    parameter int REP_CYC     = KEY_REP_CYC_DEF,
    parameter int PULSE_CYC   = 2,
    parameter int GUARD_CYC   = 2
) (
    input  logic clk,
    input  logic clr_n,
    input  logic en,
    input  logic key_m,
    input  logic key_h,
    output logic madd,
    output logic madd_sig,
    output logic hadd,
    output logic hadd_sig
);

    localparam int TW = timer_width((HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC);
    localparam int PW = timer_width((PULSE_CYC > GUARD_CYC) ? PULSE_CYC : GUARD_CYC);

    localparam logic [TW-1:0] HOLD_LOAD  = TW'(HOLD_CYC);
    localparam logic [TW-1:0] REP_LOAD   = TW'(REP_CYC);
    localparam logic [PW-1:0] PULSE_LOAD = PW'(PULSE_CYC - 1);
    localparam logic [PW-1:0] GUARD_LOAD = PW'(GUARD_CYC - 1);

    logic [1:0] key_vec;
    logic [1:0] add_vec;
    logic [1:0] sig_vec;

    assign key_vec = {key_h, key_m};

    // Channel 0 is minutes, channel 1 is hours; they share nothing but clk/en.
    for (genvar gi = 0; gi < 2; gi++) begin : g_ch
        logic          stable;
        logic          rise;
        logic          fall;
        key_state_e    state_reg;
        key_state_e    state_next;
        logic [TW-1:0] timer_reg;
        logic [TW-1:0] timer_next;
        logic [PW-1:0] phase_reg;
        logic [PW-1:0] phase_next;
        logic          add_reg;
        logic          sig_reg;
        logic          add_next;
        logic          sig_next;

        key_debounce #(
            .SYNC_STAGES (SYNC_STAGES),
            .DEB_CYC     (DEB_CYC)
        ) u_deb (
            .clk    (clk),
            .clr_n  (clr_n),
            .key    (key_vec[gi]),
            .stable (stable),
            .rise   (rise),
            .fall   (fall)
        );

        // State, timers and the registered add/sig outputs.
        always_ff @(posedge clk or negedge clr_n) begin
            if (!clr_n) begin
                state_reg <= IDLE;
                timer_reg <= '0;
                phase_reg <= '0;
                add_reg   <= 1'b0;
                sig_reg   <= 1'b0;
            end else begin
                state_reg <= state_next;
                timer_reg <= timer_next;
                phase_reg <= phase_next;
                add_reg   <= add_next;
                sig_reg   <= sig_next;
            end
        end

        // Next state; outputs decoded from the next state so they leave flops directly.
        always_comb begin
            state_next = state_reg;
            phase_next = phase_reg;
            timer_next = timer_reg;
            // Repeat timer counts down toward the next repeat rise and sticks at 0.
            if (timer_reg != '0) begin
                timer_next = timer_reg - TW'(1);
            end
            case (state_reg)
                IDLE: begin
                    if (rise && en) begin
                        state_next = ARM;
                    end
                end
                ARM: begin
                    // Timer is loaded on the edge where add rises.
                    state_next = PULSE;
                    timer_next = HOLD_LOAD;
                    phase_next = PULSE_LOAD;
                end
                PULSE: begin
                    // A pulse always runs to completion, even if the key was let go.
                    if (phase_reg == '0) begin
                        state_next = GAP;
                    end else begin
                        phase_next = phase_reg - PW'(1);
                    end
                end
                GAP: begin
                    // Release beats a repeat expiry landing on the same edge.
                    if (!stable || fall) begin
                        state_next = GUARD;
                        phase_next = GUARD_LOAD;
                    end else if (timer_reg <= TW'(1)) begin
                        state_next = PULSE;
                        timer_next = REP_LOAD;
                        phase_next = PULSE_LOAD;
                    end
                end
                GUARD: begin
                    if (phase_reg == '0) begin
                        state_next = IDLE;
                    end else begin
                        phase_next = phase_reg - PW'(1);
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
            sig_next = (state_next != IDLE);
            add_next = (state_next == PULSE);
        end

        assign add_vec[gi] = add_reg;
        assign sig_vec[gi] = sig_reg;
    end

    assign madd     = add_vec[0];
    assign madd_sig = sig_vec[0];
    assign hadd     = add_vec[1];
    assign hadd_sig = sig_vec[1];

endmodule

// File: tb/tb_key_adjust_ctrl.sv
// Directed bench for key_adjust_ctrl with short timings. Edge 0 of each run is
// the posedge after which the key is first driven high; outputs are sampled
// 1 ns after each posedge.
module tb_key_adjust_ctrl;

    logic clk = 1'b0;
    logic clr_n;
    logic en;
    logic key_m;
    logic key_h;
    logic madd;
    logic madd_sig;
    logic hadd;
    logic hadd_sig;

    int checks = 0;
    int errors = 0;

    // Expected waveform per run: sig high for cycles [on, off), add high
    // for two cycles starting at each listed rise.
    int m_rises[$];
    int h_rises[$];
    int m_sig_on, m_sig_off, h_sig_on, h_sig_off;
    // Stimulus windows per run.
    int m_on, m_off, h_on, h_off, en_lo, en_hi;
    bit bounce;
    bit inv_en = 1'b0;

    key_adjust_ctrl #(
        .SYNC_STAGES (2),
        .DEB_CYC     (4),
        .HOLD_CYC    (10),
        .REP_CYC     (5),
        .PULSE_CYC   (2),
        .GUARD_CYC   (2)
    ) dut (
        .clk      (clk),
        .clr_n    (clr_n),
        .en       (en),
        .key_m    (key_m),
        .key_h    (key_h),
        .madd     (madd),
        .madd_sig (madd_sig),
        .hadd     (hadd),
        .hadd_sig (hadd_sig)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp, input int k);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cycle %0d observed %b expected %b", tag, k, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic in_pulse(input int k, input int rises[$]);
        foreach (rises[i]) begin
            if (k >= rises[i] && k < rises[i] + 2) return 1'b1;
        end
        return 1'b0;
    endfunction

    // One directed run of n cycles: check all outputs each cycle, then drive inputs.
    task automatic run(input string name, input int n);
        int   m_cnt;
        int   h_cnt;
        logic pm;
        logic ph;
        m_cnt = 0;
        h_cnt = 0;
        pm = 1'b0;
        ph = 1'b0;
        for (int k = 0; k < n; k++) begin
            step();
            chk({name, " madd_sig"}, madd_sig, (k >= m_sig_on && k < m_sig_off), k);
            chk({name, " madd"}, madd, in_pulse(k, m_rises), k);
            chk({name, " hadd_sig"}, hadd_sig, (k >= h_sig_on && k < h_sig_off), k);
            chk({name, " hadd"}, hadd, in_pulse(k, h_rises), k);
            if (madd === 1'b1 && pm !== 1'b1) m_cnt++;
            if (hadd === 1'b1 && ph !== 1'b1) h_cnt++;
            pm = madd;
            ph = hadd;
            if (bounce) key_m = (k < 40) && ((k / 3) % 2 == 0);
            else        key_m = (k >= m_on && k < m_off);
            key_h = (k >= h_on && k < h_off);
            en    = !(k >= en_lo && k < en_hi);
        end
        chk_int({name, " madd rises"}, m_cnt, m_rises.size());
        chk_int({name, " hadd rises"}, h_cnt, h_rises.size());
        $display("run %s: %0d cycles, madd rises %0d, hadd rises %0d", name, n, m_cnt, h_cnt);
    endtask

    // Per-cycle invariants: add implies sig, sig set up before add, guard before sig drops.
    logic [1:0] prev_add = 2'b00;
    logic [1:0] prev_sig = 2'b00;
    int         low_cnt[2] = '{0, 0};
    always @(negedge clk) begin
        logic [1:0] a;
        logic [1:0] s;
        a = {hadd, madd};
        s = {hadd_sig, madd_sig};
        if (inv_en) begin
            for (int c = 0; c < 2; c++) begin
                checks++;
                assert (!(a[c] === 1'b1 && s[c] !== 1'b1)) else begin
                    errors++;
                    $error("FAIL inv add_without_sig ch%0d observed add=%b sig=%b expected sig=1", c, a[c], s[c]);
                end
                if (a[c] === 1'b1 && prev_add[c] !== 1'b1) begin
                    checks++;
                    assert (prev_sig[c] === 1'b1) else begin
                        errors++;
                        $error("FAIL inv sig_setup ch%0d observed prev_sig=%b expected 1", c, prev_sig[c]);
                    end
                end
                if (s[c] === 1'b0 && prev_sig[c] === 1'b1) begin
                    checks++;
                    assert (low_cnt[c] >= 2) else begin
                        errors++;
                        $error("FAIL inv guard ch%0d observed add_low=%0d expected >=2", c, low_cnt[c]);
                    end
                end
            end
        end
        for (int c = 0; c < 2; c++) begin
            low_cnt[c] = (a[c] === 1'b1) ? 0 : low_cnt[c] + 1;
        end
        prev_add = a;
        prev_sig = s;
    end

    initial begin
        clr_n  = 1'b1;
        en     = 1'b1;
        key_m  = 1'b0;
        key_h  = 1'b0;
        bounce = 1'b0;
        m_on = 0; m_off = 0; h_on = 0; h_off = 0;
        en_lo = 0; en_hi = 0;
        #2 clr_n = 1'b0;
        step();
        step();
        chk("reset madd", madd, 1'b0, 0);
        chk("reset madd_sig", madd_sig, 1'b0, 0);
        chk("reset hadd", hadd, 1'b0, 0);
        chk("reset hadd_sig", hadd_sig, 1'b0, 0);
        clr_n = 1'b1;
        step();
        step();
        inv_en = 1'b1;

        // 1 clean tap on minutes
        m_on = 0; m_off = 12; h_on = 0; h_off = 0;
        m_rises = '{8}; h_rises = {};
        m_sig_on = 7; m_sig_off = 20; h_sig_on = 0; h_sig_off = 0;
        run("tap", 30);

        // 2 bouncing key never settles
        bounce = 1'b1;
        m_rises = {}; h_rises = {};
        m_sig_on = 0; m_sig_off = 0;
        run("bounce", 50);
        bounce = 1'b0;

        // 3 auto-repeat while held
        m_on = 0; m_off = 30;
        m_rises = '{8, 18, 23, 28, 33};
        m_sig_on = 7; m_sig_off = 38;
        run("repeat", 45);

        // 4 both keys together
        m_on = 0; m_off = 12; h_on = 0; h_off = 12;
        m_rises = '{8}; h_rises = '{8};
        m_sig_on = 7; m_sig_off = 20; h_sig_on = 7; h_sig_off = 20;
        run("simul", 30);

        // 5a press with en low is ignored
        h_on = 0; h_off = 0;
        en = 1'b0; en_lo = 0; en_hi = 1000;
        m_rises = {}; h_rises = {};
        m_sig_on = 0; m_sig_off = 0; h_sig_on = 0; h_sig_off = 0;
        run("en_off", 30);

        // 5b en drops during auto-repeat: sequence runs on until release
        en = 1'b1; en_lo = 20; en_hi = 1000;
        m_on = 0; m_off = 30;
        m_rises = '{8, 18, 23, 28, 33};
        m_sig_on = 7; m_sig_off = 38;
        run("en_drop", 45);

        // 5c en still low: next press ignored
        en_lo = 0;
        m_off = 12;
        m_rises = {};
        m_sig_on = 0; m_sig_off = 0;
        run("en_after", 30);

        // 6 reset in the middle of a pulse, key kept held
        en = 1'b1;
        step();
        key_m = 1'b1;
        for (int k = 1; k <= 8; k++) step();
        chk("prerst madd", madd, 1'b1, 8);
        chk("prerst madd_sig", madd_sig, 1'b1, 8);
        #2;
        inv_en = 1'b0;
        clr_n  = 1'b0;
        #1;
        chk("async madd", madd, 1'b0, 8);
        chk("async madd_sig", madd_sig, 1'b0, 8);
        chk("async hadd", hadd, 1'b0, 8);
        chk("async hadd_sig", hadd_sig, 1'b0, 8);
        $display("reset applied mid-pulse, outputs madd=%b madd_sig=%b", madd, madd_sig);
        step();
        step();
        clr_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (k == 1) inv_en = 1'b1;
            chk("rst_relatch madd_sig", madd_sig, (k >= 7), k);
            chk("rst_relatch madd", madd, (k == 8 || k == 9), k);
        end
        key_m = 1'b0;
        for (int k = 0; k < 30; k++) step();
        chk("final madd_sig", madd_sig, 1'b0, 0);
        chk("final hadd_sig", hadd_sig, 1'b0, 0);
        $display("reset relatch sequence complete");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
